// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the async-FIFO read-side arbiter: default sizing
// and the two-state arbitration FSM encoding.
package fifo_arb_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DSIZE_DEF = 8;
    localparam int BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : fifo_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority picker: starting one past the last served channel, return
// the first requesting channel (wrapping modulo NCH) and whether any requested.
module rr_pick #(
    parameter int NCH = 4,
    localparam int CW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req_i,
    input  logic [CW-1:0]  last_i,
    output logic           hit_o,
    output logic [CW-1:0]  idx_o
);

    logic          hit_s;
    logic [CW-1:0] idx_s;
    logic [CW-1:0] cand_s;
    logic          take_s;

    // Walk last+1 .. last+NCH and latch the first requester seen.
    always_comb begin
        hit_s  = 1'b0;
        idx_s  = '0;
        cand_s = '0;
        take_s = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = CW'((int'(last_i) + k) % NCH);
            take_s = ~hit_s & req_i[cand_s];
            hit_s  = hit_s | take_s;
            idx_s  = take_s ? cand_s : idx_s;
        end
    end

    assign hit_o = hit_s;
    assign idx_o = idx_s;

endmodule : rr_pick

// File: rtl/fifo_rd_arb.sv
// Round-robin read arbiter over NCH show-ahead FIFOs sharing rd_clk.
// A grant pops up to BURST words from one channel into a registered output
// stage, then always returns to IDLE for one rearbitration cycle.
module fifo_rd_arb
    import fifo_arb_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DSIZE = DSIZE_DEF,
    parameter int BURST = BURST_DEF,
    localparam int CW   = $clog2(NCH)
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic [NCH-1:0]       rd_empty,
    input  logic [NCH*DSIZE-1:0] rd_data_bus,
    output logic [NCH-1:0]       rd_en,
    input  logic [NCH-1:0]       ch_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DSIZE-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    output logic                 busy
);

    // Beat count value at which the current pop is the last of the burst.
    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CW-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]    last_q, last_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic             out_valid_q, out_valid_d;
    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_ch_q, out_ch_d;

    logic [NCH-1:0]   req_s;
    logic             hit_s;
    logic [CW-1:0]    idx_s;
    logic             accept_s;
    logic             pop_s;
    logic [NCH-1:0]   rd_en_s;
    logic [DSIZE-1:0] head_s;

    // A channel competes only when it has data and is enabled.
    assign req_s    = ~rd_empty & ch_en;
    // The output register can take a new word when empty or being drained.
    assign accept_s = ~out_valid_q | out_ready;
    assign head_s   = rd_data_bus[int'(gnt_q)*DSIZE +: DSIZE];

    rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req_i  (req_s),
        .last_i (last_q),
        .hit_o  (hit_s),
        .idx_o  (idx_s)
    );

    // Arbitration FSM: pick in IDLE, pop in GRANT, leave on burst end/empty/disable.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        bcnt_d  = bcnt_q;
        pop_s   = 1'b0;
        rd_en_s = '0;
        case (state_q)
            IDLE: begin
                if (hit_s) begin
                    state_d = GRANT;
                    gnt_d   = idx_s;
                    bcnt_d  = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                pop_s          = ~rd_empty[gnt_q] & ch_en[gnt_q] & accept_s;
                rd_en_s[gnt_q] = pop_s;
                if (pop_s) begin
                    bcnt_d = bcnt_q + 8'd1;
                end else begin
                    bcnt_d = bcnt_q;
                end
                if ((pop_s && (bcnt_q == LAST_BEAT)) || rd_empty[gnt_q] || !ch_en[gnt_q]) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: load on pop, drop valid on handshake without pop, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (pop_s) begin
            out_valid_d = 1'b1;
            out_data_d  = head_s;
            out_ch_d    = gnt_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // FSM state, grant and burst bookkeeping; last starts at NCH-1 so ch0 wins first.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= CW'(NCH - 1);
            bcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Registered output word; reset discards any word still held.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign rd_en     = rd_en_s;
    assign busy      = (state_q == GRANT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule : fifo_rd_arb

// File: tb/tb_fifo_rd_arb.sv
// Directed and randomized bench for fifo_rd_arb (NCH=4, DSIZE=8, BURST=4).
// Each channel is modelled as an endless show-ahead FIFO whose word is
// {channel, sequence number}; a per-channel acceptance counter checks order.
module tb_fifo_rd_arb;

    localparam int NCH   = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int CW    = 2;
    localparam int BIG   = 1000000;

    logic                 rd_clk = 1'b0;
    logic                 rd_rst_n;
    logic [NCH-1:0]       rd_empty;
    logic [NCH*DSIZE-1:0] rd_data_bus;
    logic [NCH-1:0]       rd_en;
    logic [NCH-1:0]       ch_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [DSIZE-1:0]     out_data;
    logic [CW-1:0]        out_ch;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rp   [NCH];
    int fill [NCH];
    int acc  [NCH];
    logic [NCH-1:0] blk_s;
    logic [NCH-1:0] s_rden;
    logic           s_busy;
    int start0;
    int sum_rp;
    int sum_acc;

    fifo_rd_arb #(
        .NCH   (NCH),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rst_n    (rd_rst_n),
        .rd_empty    (rd_empty),
        .rd_data_bus (rd_data_bus),
        .rd_en       (rd_en),
        .ch_en       (ch_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .busy        (busy)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < NCH; i++) begin
            rd_empty[i] = (rp[i] >= fill[i]) | blk_s[i];
            rd_data_bus[i*DSIZE +: DSIZE] = {2'(i), 6'(rp[i] + 1)};
        end
    endtask

    // One clock: sample at negedge, score accepted words, advance FIFO heads after the edge.
    task automatic step();
        drive_fifos();
        @(negedge rd_clk);
        s_rden = rd_en;
        s_busy = busy;
        check_eq("onehot_rd_en", 32'($onehot0(rd_en)), 32'd1);
        check_eq("rd_en_vs_empty", 32'(rd_en & rd_empty), 32'd0);
        if (out_valid && out_ready) begin
            check_eq("sb_word", 32'(out_data), 32'({out_ch, 6'(acc[out_ch] + 1)}));
            acc[out_ch]++;
        end
        @(posedge rd_clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (s_rden[i]) rp[i]++;
        end
        drive_fifos();
    endtask

    task automatic vecn(input string tag, input logic [NCH-1:0] exp_en, input logic exp_busy, input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check_eq({tag, "_rd_en"}, 32'(s_rden), 32'(exp_en));
            check_eq({tag, "_busy"}, 32'(s_busy), 32'(exp_busy));
        end
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        drive_fifos();
        repeat (2) @(posedge rd_clk);
        #1;
        for (int i = 0; i < NCH; i++) acc[i] = rp[i];
        rd_rst_n = 1'b1;
    endtask

    initial begin
        rd_rst_n    = 1'b0;
        out_ready   = 1'b1;
        ch_en       = 4'hF;
        blk_s       = 4'h0;
        rd_empty    = 4'hF;
        rd_data_bus = '0;
        for (int i = 0; i < NCH; i++) begin
            rp[i] = 0; acc[i] = 0; fill[i] = BIG;
        end

        // Reset state with all FIFOs non-empty
        drive_fifos();
        repeat (2) @(posedge rd_clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_ch", 32'(out_ch), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd_en", 32'(rd_en), 32'd0);
        rd_rst_n = 1'b1;

        // Full rotation: 4 pops per channel with a one-cycle bubble between grants
        vecn("t2_first_idle", 4'b0000, 1'b0, 1);
        vecn("t2_ch0", 4'b0001, 1'b1, 4);
        vecn("t2_idle", 4'b0000, 1'b0, 1);
        vecn("t2_ch1_first", 4'b0010, 1'b1, 1);
        check_eq("t2_out_ch1", 32'(out_ch), 32'd1);
        check_eq("t2_out_data1", 32'(out_data), 32'h41);
        check_eq("t2_out_valid", 32'(out_valid), 32'd1);
        vecn("t2_ch1", 4'b0010, 1'b1, 3);
        vecn("t2_idle", 4'b0000, 1'b0, 1);
        vecn("t2_ch2", 4'b0100, 1'b1, 4);
        vecn("t2_idle", 4'b0000, 1'b0, 1);
        vecn("t2_ch3", 4'b1000, 1'b1, 4);
        vecn("t2_idle", 4'b0000, 1'b0, 1);
        vecn("t2_wrap_ch0", 4'b0001, 1'b1, 1);

        // Only ch2 holds 2 words: short grant ends when it runs empty
        for (int i = 0; i < NCH; i++) fill[i] = rp[i];
        fill[2] = rp[2] + 2;
        do_reset();
        vecn("t3_idle", 4'b0000, 1'b0, 1);
        vecn("t3_pop", 4'b0100, 1'b1, 2);
        vecn("t3_empty_exit", 4'b0000, 1'b1, 1);
        vecn("t3_idle_nohit", 4'b0000, 1'b0, 2);
        check_eq("t3_pops", 32'(rp[2] - fill[2]), 32'd0);

        // Back-pressure for 5 cycles mid-burst
        for (int i = 0; i < NCH; i++) fill[i] = BIG;
        start0 = rp[0];
        do_reset();
        vecn("t4_idle", 4'b0000, 1'b0, 1);
        vecn("t4_pop", 4'b0001, 1'b1, 1);
        out_ready = 1'b0;
        vecn("t4_stall", 4'b0000, 1'b1, 5);
        check_eq("t4_held_valid", 32'(out_valid), 32'd1);
        check_eq("t4_held_data", 32'(out_data), 32'({2'd0, 6'(start0 + 1)}));
        out_ready = 1'b1;
        vecn("t4_resume", 4'b0001, 1'b1, 3);
        vecn("t4_idle", 4'b0000, 1'b0, 1);
        check_eq("t4_total", 32'(rp[0] - start0), 32'd4);

        // ch_en[1] dropped during ch1 grant
        do_reset();
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_ch0", 4'b0001, 1'b1, 4);
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_ch1", 4'b0010, 1'b1, 1);
        ch_en = 4'b1101;
        vecn("t5_dis_exit", 4'b0000, 1'b1, 1);
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_ch2", 4'b0100, 1'b1, 4);
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_ch3", 4'b1000, 1'b1, 4);
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_ch0b", 4'b0001, 1'b1, 4);
        vecn("t5_idle", 4'b0000, 1'b0, 1);
        vecn("t5_skip1", 4'b0100, 1'b1, 1);
        ch_en = 4'hF;

        // Asynchronous reset mid-burst
        do_reset();
        vecn("t6_idle", 4'b0000, 1'b0, 1);
        vecn("t6_pop", 4'b0001, 1'b1, 2);
        rd_rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(out_valid), 32'd0);
        check_eq("t6_data", 32'(out_data), 32'd0);
        check_eq("t6_ch", 32'(out_ch), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_rd_en", 32'(rd_en), 32'd0);
        fill[0] = rp[0];
        drive_fifos();
        @(posedge rd_clk);
        #1;
        for (int i = 0; i < NCH; i++) acc[i] = rp[i];
        rd_rst_n = 1'b1;
        vecn("t6_post_idle", 4'b0000, 1'b0, 1);
        vecn("t6_lowest", 4'b0010, 1'b1, 1);
        check_eq("t6_out_ch", 32'(out_ch), 32'd1);

        // Random empty flags and back-pressure with scoreboard
        for (int i = 0; i < NCH; i++) fill[i] = BIG;
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            blk_s     = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        blk_s     = 4'h0;
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) fill[i] = rp[i];
        repeat (10) step();
        sum_rp  = 0;
        sum_acc = 0;
        for (int i = 0; i < NCH; i++) begin
            sum_rp  += rp[i];
            sum_acc += acc[i];
            check_eq("rand_per_ch", 32'(acc[i]), 32'(rp[i]));
        end
        check_eq("rand_total", 32'(sum_acc), 32'(sum_rp));
        check_eq("rand_drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_rd_arb

// File: doc/fifo_rd_arb.md
FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 Parameter NCH, default 4: number of async-FIFO read ports served (2..16).
REQ-002 Parameter DSIZE, default 8: data width per FIFO.
REQ-003 Parameter BURST, default 4: maximum pops per grant (1..256).
REQ-004 Localparam CW = $clog2(NCH): channel index width.
REQ-005 rd_clk  input  1  the single clock, the read-side clock of all served FIFOs.
REQ-006 rd_rst_n  input  1  reset, asynchronous and active-low.
REQ-007 rd_empty  input  NCH  per-channel FIFO empty flag, synchronous to rd_clk.
REQ-008 rd_data_bus  input  NCH*DSIZE  channel i head word at bits [i*DSIZE +: DSIZE], valid combinationally while rd_empty[i]=0 (show-ahead).
REQ-009 rd_en  output  NCH  per-channel pop strobe, at most one bit set per cycle.
REQ-010 ch_en  input  NCH  per-channel arbitration enable mask.
REQ-011 out_valid  output  1  out_data/out_ch hold a word.
REQ-012 out_ready  input  1  downstream accepts the word when out_valid=1.
REQ-013 out_data  output  DSIZE  popped word, registered.
REQ-014 out_ch  output  CW  source channel of out_data, registered.
REQ-015 busy  output  1  high while state is GRANT.

Function
REQ-016 The FSM shall have two states, IDLE and GRANT, plus registers gnt (CW), last (CW), and bcnt (8 bits).
REQ-017 accept = ~out_valid | out_ready.
REQ-018 In IDLE, the block shall search round-robin from last+1 (modulo NCH) for the first i with ~rd_empty[i] & ch_en[i]. On a hit, it shall load gnt=i, clear bcnt, and enter GRANT on the next edge. With no hit, it shall stay in IDLE.
REQ-019 In GRANT: rd_en[gnt] = ~rd_empty[gnt] & ch_en[gnt] & accept (combinational). All other rd_en bits shall be 0, and every rd_en bit shall be 0 in IDLE.
REQ-020 rd_en[i] shall never assert while rd_empty[i]=1.
REQ-021 A pop shall register out_data = rd_data_bus[gnt], out_ch = gnt, and out_valid = 1 on the same edge, giving 1-cycle latency from rd_en to out_valid.
REQ-022 Without a pop, a cycle with out_valid & out_ready shall clear out_valid. Otherwise out_valid/out_data/out_ch shall hold their values.
REQ-023 Each pop shall increment bcnt.
REQ-024 GRANT shall exit to IDLE, with last = gnt, when any of the following holds:
  - a pop occurs with bcnt = BURST-1;
  - rd_empty[gnt]=1;
  - ch_en[gnt]=0.
REQ-025 Every grant ends with one IDLE cycle, so a rearbitration bubble of exactly 1 cycle exists.
REQ-026 Back-pressure (out_ready=0 with out_valid=1) shall stall GRANT without exiting or changing bcnt.
REQ-027 If rd_empty[gnt] rises on the cycle after a pop, the grant shall end even when bcnt < BURST.
REQ-028 BURST=1: every grant shall pop exactly one word.
REQ-029 Single active channel: that channel shall be re-granted after each IDLE cycle.
REQ-030 Throughput with out_ready held at 1 shall be BURST words per BURST+1 cycles.

Reset
REQ-031 While rd_rst_n=0, asynchronously:
  - state = IDLE, gnt = 0, last = NCH-1 (so channel 0 wins first), bcnt = 0;
  - out_valid = 0, out_data = 0, out_ch = 0;
  - busy = 0, rd_en = 0.
REQ-032 Reset asserted mid-burst shall discard any held word. No pop shall occur in the first cycle after deassertion.

Structure
REQ-033 Package fifo_arb_pkg shall hold the state encodings (IDLE=1'b0, GRANT=1'b1) and the default NCH/DSIZE/BURST values.
REQ-034 Sub-module rr_pick (combinational rotating-priority picker) shall take the request vector and last, and return a hit flag and index.
REQ-035 All sequential logic shall be in fifo_rd_arb, clocked on rd_clk with async rd_rst_n.

Verification
REQ-036 After reset, ch0..ch3 nonempty, out_ready=1, BURST=4 -> pop order 0,0,0,0,bubble,1,1,1,1,bubble,2...; out_ch matches.
REQ-037 ch2 only, holding 2 words -> 2 pops, rd_empty[2] rises, IDLE; rd_en never high while rd_empty=1.
REQ-038 out_ready=0 for 5 cycles mid-burst -> exactly one held word and no rd_en. On release, the burst continues and the total is 4 words.
REQ-039 ch_en[1] cleared during ch1 grant -> grant ends next edge. ch1 is skipped until re-enabled, and the remaining channels rotate.
REQ-040 rd_rst_n pulsed low mid-burst -> outputs immediately 0. After release, the first grant goes to the lowest nonempty channel.
REQ-041 Scoreboard with random rd_empty/out_ready for 10k cycles, NCH=4 -> no data loss or duplication, at most one rd_en bit per cycle, per-channel order preserved.
